// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// The unit is built for DATA_WIDTH = 32; the constants below are 32 bits wide.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] SIGNED_MIN    = 32'h8000_0000;

endpackage

// File: rtl/muldiv_iter_core.sv
// One radix-2 step: shift-add for multiply, shift/trial-subtract for divide.
// The divide step exists only when MULDIV_DIV_EN is defined.
module muldiv_iter_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2*DATA_WIDTH-1:0] i_acc,
  input  logic [DATA_WIDTH-1:0]   i_opnd,
  input  logic                    i_bit,
  input  logic                    i_is_div,
  output logic [2*DATA_WIDTH-1:0] o_acc
);

  localparam int W = DATA_WIDTH;

  logic [W:0] w_sum;

`ifdef MULDIV_DIV_EN
  logic [W:0] w_rem_sh;
  logic [W:0] w_diff;
  logic       w_ge;
`else
  logic       w_unused;
  assign w_unused = ^{i_is_div, i_acc[0]};
`endif

  always_comb begin
    // Multiply: the carry out of the upper-half add becomes the new MSB.
    w_sum = {1'b0, i_acc[2*W-1:W]} + (i_bit ? {1'b0, i_opnd} : '0);
    o_acc = {w_sum, i_acc[W-1:1]};
`ifdef MULDIV_DIV_EN
    w_rem_sh = {i_acc[2*W-1:W], i_bit};
    w_diff   = w_rem_sh - {1'b0, i_opnd};
    w_ge     = (w_rem_sh >= {1'b0, i_opnd});
    if (i_is_div) begin
      o_acc = {(w_ge ? w_diff[W-1:0] : w_rem_sh[W-1:0]), i_acc[W-2:0], w_ge};
    end
`endif
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with busy/done stall handshake.
// MULDIV_DIV_EN enables the divide/remainder datapath; otherwise divides return 0 early.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] SRCA,
  input  logic [DATA_WIDTH-1:0] SRCB,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output state_e                dbg_state
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  // Handshake: start is accepted only in IDLE without flush; busy is high
  // in CALC/FIX; done pulses one cycle in DONE, when result is valid.
  state_e            r_state, w_next;
  op_e               r_op;
  logic [W-1:0]      r_opa, r_opb, r_result;
  logic [2*W-1:0]    r_acc;
  logic [CW-1:0]     r_cnt;
  logic              r_sign_a, r_sign_b, r_fix2;

  op_e               w_op;
  logic              w_accept, w_sa, w_sb, w_early, w_is_div, w_bit;
  logic [W-1:0]      w_abs_a, w_abs_b, w_early_val, w_sel;
  logic [2*W-1:0]    w_core_acc, w_fixed;

  always_comb begin
    w_op     = op_e'(op);
    w_accept = start && !flush;
    w_sa     = SRCA[W-1] && (w_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    w_sb     = SRCB[W-1] && (w_op inside {OP_MULH, OP_DIV, OP_REM});
    w_abs_a  = w_sa ? -SRCA : SRCA;
    w_abs_b  = w_sb ? -SRCB : SRCB;
`ifdef MULDIV_DIV_EN
    w_early     = op[2] && ((SRCB == '0) ||
                  (!op[0] && SRCA == SIGNED_MIN && SRCB == DIV_BY_ZERO_Q));
    if (SRCB == '0) w_early_val = op[1] ? SRCA : DIV_BY_ZERO_Q;
    else            w_early_val = op[1] ? '0 : SIGNED_MIN;
`else
    w_early     = op[2];
    w_early_val = '0;
`endif
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next = w_early ? DONE : CALC;
      CALC: if (flush) w_next = IDLE;
            else if (r_cnt == CW'(DATA_WIDTH - 1)) w_next = FIX;
      FIX:  if (flush) w_next = IDLE;
            else if (r_fix2) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    busy      = (r_state == CALC) || (r_state == FIX);
    done      = (r_state == DONE);
    result    = r_result;
    dbg_state = r_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Divide feeds dividend bits MSB first; multiply consumes multiplier bits LSB first.
  assign w_is_div = r_op[2];
  assign w_bit    = w_is_div ? r_opa[CW'(DATA_WIDTH - 1) - r_cnt] : r_opb[r_cnt];

  muldiv_iter_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .i_acc    (r_acc),
    .i_opnd   (w_is_div ? r_opb : r_opa),
    .i_bit    (w_bit),
    .i_is_div (w_is_div),
    .o_acc    (w_core_acc)
  );

  always_comb begin
    w_fixed = r_acc;
    if (w_is_div) begin
`ifdef MULDIV_DIV_EN
      w_fixed[W-1:0]   = (r_sign_a ^ r_sign_b) ? -r_acc[W-1:0] : r_acc[W-1:0];
      w_fixed[2*W-1:W] = r_sign_a ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
`endif
    end else if (r_sign_a ^ r_sign_b) begin
      w_fixed = -r_acc;
    end
    w_sel = (r_op inside {OP_MUL, OP_DIV, OP_DIVU}) ? r_acc[W-1:0] : r_acc[2*W-1:W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= OP_MUL;
      r_opa    <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_fix2   <= 1'b0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_accept) begin
          r_op     <= w_op;
          r_opa    <= w_abs_a;
          r_opb    <= w_abs_b;
          r_sign_a <= w_sa;
          r_sign_b <= w_sb;
          r_acc    <= '0;
          r_cnt    <= '0;
          r_fix2   <= 1'b0;
          if (w_early) r_result <= w_early_val;
        end
        CALC: begin
          r_acc <= w_core_acc;
          r_cnt <= r_cnt + 1'b1;
        end
        // FIX takes two cycles: sign correction, then result selection.
        FIX: if (!flush) begin
          if (!r_fix2) begin
            r_acc  <= w_fixed;
            r_fix2 <= 1'b1;
          end else begin
            r_result <= w_sel;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, beside the single-cycle ALU. It takes the same SRCA/SRCB operands and produces a 32-bit result for the writeback mux. It stalls the pipeline through a busy/done handshake while a radix-2 shift-add multiply or restoring divide runs. Divide-by-zero and signed-overflow cases complete early with the RISC-V-defined results.

## Interface
- DATA_WIDTH, 32: operand and result width; the iteration count equals DATA_WIDTH.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  3  funct3 code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SRCA  input  DATA_WIDTH  rs1 operand (multiplicand / dividend).
- SRCB  input  DATA_WIDTH  rs2 operand (multiplier / divisor).
- flush  input  1  abort the operation in flight.
- busy  output  1  operation in progress; the hazard unit stalls on this.
- done  output  1  one-cycle pulse when result is valid.
- result  output  DATA_WIDTH  final result; held until the next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start, latch op and the absolute values of the operands.
  - Operand signedness: MULH and DIV/REM treat both operands as signed. MULHSU treats only SRCA as signed. All other ops are unsigned.
  - Latch the result signs:
    - Product sign = signA XOR signB.
    - Quotient sign = signA XOR signB.
    - Remainder sign = signA.
  - Clear the 2·DATA_WIDTH accumulator and the iteration counter, then go to CALC.
- Early-out, checked in IDLE on start. Go directly to DONE with result preloaded:
  - Divisor 0, DIV/DIVU: all ones.
  - Divisor 0, REM/REMU: SRCA.
  - DIV with 0x80000000 / 0xFFFFFFFF: 0x80000000.
  - REM with the same operands: 0.
- CALC:
  - Exactly DATA_WIDTH iterations; counter 0..DATA_WIDTH-1, leave on terminal count.
  - Multiply: if the multiplier LSB is set, add the multiplicand to the upper half, then shift right by one. The 64-bit product is unsigned on magnitudes.
  - Divide: shift {remainder, quotient} left by one, trial-subtract the divisor, and set the quotient bit if the result is non-negative.
- FIX:
  - Two's-complement negate the product/quotient/remainder if its latched sign requires it.
  - Select the result: low word for MUL, high word for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
- DONE: assert done for one cycle, then return to IDLE. result stays stable.
- busy = 1 in CALC and FIX. busy = 0 in IDLE and DONE.
- start outside IDLE is ignored, with no queuing.
- flush in CALC or FIX: return to IDLE on the next edge. No done pulse; result is unchanged.
- flush in DONE has no effect, because that cycle's done still fires.
- flush and start together in IDLE: flush wins and the start is dropped.

## Timing
- Reset (asynchronous): state IDLE, busy 0, done 0, result 0, counter 0.
- Normal latency, with start sampled at edge E0:
  - busy is high from after E0 through E0+33.
  - done is high for the single cycle after edge E0+34.
- Early-out latency: done is high in the cycle after E0, and busy never asserts.
- Back-to-back: a start during the done cycle is ignored. The earliest new start is in the IDLE cycle that follows.
- Reset mid-operation aborts immediately, and no done is ever produced for that operation.

## Configuration
- MULDIV_DIV_EN:
  - Defined: full behaviour above.
  - Undefined: the divide datapath, divisor-zero/overflow checks and remainder logic are compiled out. DIV/DIVU/REM/REMU take the early-out path with result 0 (done in the cycle after E0). Multiply is unchanged.

## Structure
- Shared package muldiv_pkg contains:
  - op_e enum for the eight funct3 codes.
  - state_e enum (IDLE, CALC, FIX, DONE).
  - DIV_BY_ZERO_Q constant (all ones).
  - SIGNED_MIN constant (0x80000000).
- One sub-module, muldiv_iter_core: the per-iteration add/subtract-and-shift step (combinational, DATA_WIDTH generic). The FSM, counter, operand latches and sign fix stay in muldiv_unit.

## Test plan
- MUL 7 × 0xFFFFFFFD → result 0xFFFFFFEB; done at E0+34 cycles; busy high for 34 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- Early-out cases, each with done in the cycle after start and busy never high:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
- start pulsed at cycle 10 of a MUL → ignored; exactly one done, at E0+34.
- flush at cycle 12 of a DIV → IDLE next edge, no done, result retains its previous value. rst at cycle 5 → busy, done and result all 0 immediately.
